// File: rtl/d_sram_if.sv
// Sram-like data bus between the data-side bridge (master) and memory (slave).
// One request per req/addr_ok handshake, completed later by data_ok.
interface d_sram_if;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  modport master (
    output data_req, data_wr, data_size, data_addr, data_wdata,
    input  data_addr_ok, data_data_ok, data_rdata
  );

  modport slave (
    input  data_req, data_wr, data_size, data_addr, data_wdata,
    output data_addr_ok, data_data_ok, data_rdata
  );
endinterface

// File: rtl/d_sram_bridge.sv
// Memory-stage load/store to sram-like bus bridge: one bus transaction per
// instruction, d_stall until data_ok, DONE holds read data across a frozen pipe.
module d_sram_bridge #(
  parameter bit KSEG_MAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_en_i,
  input  logic [3:0]  cpu_wen_i,
  input  logic [31:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic [31:0] cpu_rdata_o,
  output logic        d_stall_o,
  input  logic        longest_stall_i,
  d_sram_if.master    bus
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_e;

  state_e      state_q;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;
  logic [1:0]  lo_bits;
  logic        in_addr;
  logic        data_fin;

  // Request fields decoded from the live memory-stage inputs.
  always_comb begin
    wr_d = |cpu_wen_i;
    case (cpu_wen_i)
      4'b1111, 4'b0000:                   size_d = 2'd2;
      4'b0011, 4'b1100:                   size_d = 2'd1;
      4'b0001, 4'b0010, 4'b0100, 4'b1000: size_d = 2'd0;
      default:                            size_d = 2'd2;
    endcase
    lo_bits = 2'b00;
    if      (cpu_wen_i[0]) lo_bits = 2'd0;
    else if (cpu_wen_i[1]) lo_bits = 2'd1;
    else if (cpu_wen_i[2]) lo_bits = 2'd2;
    else if (cpu_wen_i[3]) lo_bits = 2'd3;
    addr_d = {cpu_addr_i[31:2], lo_bits};
    if (KSEG_MAP && cpu_addr_i[31:30] == 2'b10) addr_d[31:29] = 3'b000;
  end

  // Once parked in ADDR the bus sees only latched fields, so a changing
  // cpu_addr/cpu_wdata cannot corrupt a request the slave has not taken yet.
  assign in_addr         = (state_q == ADDR);
  assign data_fin        = (state_q == DATA) && bus.data_data_ok;
  assign bus.data_req    = ((state_q == IDLE) && cpu_en_i) || in_addr;
  assign bus.data_wr     = in_addr ? wr_q    : wr_d;
  assign bus.data_size   = in_addr ? size_q  : size_d;
  assign bus.data_addr   = in_addr ? addr_q  : addr_d;
  assign bus.data_wdata  = in_addr ? wdata_q : cpu_wdata_i;

  assign d_stall_o   = cpu_en_i & ((state_q == IDLE) | in_addr |
                                   ((state_q == DATA) & ~bus.data_data_ok));
  assign cpu_rdata_o = data_fin ? bus.data_rdata : rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: if (cpu_en_i) begin
          if (bus.data_addr_ok) begin
            state_q <= DATA;
          end else begin
            wr_q    <= wr_d;
            size_q  <= size_d;
            addr_q  <= addr_d;
            wdata_q <= cpu_wdata_i;
            state_q <= ADDR;
          end
        end
        ADDR: if (bus.data_addr_ok) state_q <= DATA;
        DATA: if (bus.data_data_ok) begin
          rdata_q <= bus.data_rdata;
          // Park in DONE so a frozen pipe does not re-issue the same access.
          state_q <= (longest_stall_i && cpu_en_i) ? DONE : IDLE;
        end
        DONE: if (!longest_stall_i) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_d_sram_bridge.sv
// Directed stimulus with a scoreboard: expected bus requests and load data are
// queued by the stimulus and checked by a monitor when the DUT presents them.
module tb_d_sram_bridge;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [3:0]  cwen = 4'b0;
  logic [31:0] caddr = 32'd0;
  logic [31:0] cwdata = 32'd0;
  logic [31:0] cpu_rdata;
  logic        d_stall;
  logic        ext = 1'b0;
  logic        ls;
  logic        aok = 1'b0;
  logic        dok = 1'b0;
  logic [31:0] rdat = 32'd0;

  int n_chk = 0;
  int n_fail = 0;

  req_t        exp_req_q[$];
  logic [31:0] exp_rd_q[$];

  d_sram_if bus ();

  assign bus.data_addr_ok = aok;
  assign bus.data_data_ok = dok;
  assign bus.data_rdata   = rdat;
  assign ls = d_stall | ext;

  d_sram_bridge #(.KSEG_MAP(1'b1)) dut (
    .clk(clk), .rst(rst),
    .cpu_en_i(en), .cpu_wen_i(cwen), .cpu_addr_i(caddr), .cpu_wdata_i(cwdata),
    .cpu_rdata_o(cpu_rdata), .d_stall_o(d_stall), .longest_stall_i(ls),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: accepted requests and delivered load data.
  always @(negedge clk) begin : mon
    req_t        r;
    logic [31:0] d;
    if (!rst && bus.data_req && aok) begin
      if (exp_req_q.size() == 0) chk("unexpected_req", 32'd1, 32'd0);
      else begin
        r = exp_req_q.pop_front();
        chk("req_wr",   {31'd0, bus.data_wr},   {31'd0, r.wr});
        chk("req_size", {30'd0, bus.data_size}, {30'd0, r.size});
        chk("req_addr", bus.data_addr, r.addr);
        if (r.wr) chk("req_wdata", bus.data_wdata, r.wdata);
      end
    end
    if (!rst && dok && en && cwen == 4'b0000) begin
      if (exp_rd_q.size() == 0) chk("unexpected_rdata", 32'd1, 32'd0);
      else begin
        d = exp_rd_q.pop_front();
        chk("cpu_rdata", cpu_rdata, d);
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // One access: aw cycles waiting for addr_ok, dw DATA cycles before data_ok.
  task automatic xact(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] rd, input logic [31:0] exp_addr,
                      input logic [1:0] exp_size, input int aw, input int dw);
    exp_req_q.push_back('{wr: |wen, size: exp_size, addr: exp_addr, wdata: wd});
    en = 1'b1; cwen = wen; caddr = addr; cwdata = wd; dok = 1'b0;
    for (int i = 0; i <= aw; i++) begin
      aok = (i == aw);
      @(negedge clk);
      chk("stall_issue", {31'd0, d_stall}, 32'd1);
      chk("req_issue", {31'd0, bus.data_req}, 32'd1);
      nxt();
    end
    aok = 1'b0;
    for (int i = 0; i < dw; i++) begin
      @(negedge clk);
      chk("stall_data", {31'd0, d_stall}, 32'd1);
      chk("req_data", {31'd0, bus.data_req}, 32'd0);
      nxt();
    end
    dok = 1'b1; rdat = rd;
    if (wen == 4'b0000) exp_rd_q.push_back(rd);
    @(negedge clk);
    chk("stall_dataok", {31'd0, d_stall}, 32'd0);
    nxt();
    dok = 1'b0; en = 1'b0; cwen = 4'b0; rdat = 32'h5A5A_0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req", {31'd0, bus.data_req}, 32'd0);
    chk("rst_stall", {31'd0, d_stall}, 32'd0);
    chk("rst_rdata", cpu_rdata, 32'd0);
    nxt();

    // Load word in kseg0, data_ok two cycles after issue.
    xact(4'b0000, 32'h8000_1000, 32'h0, 32'hDEAD_BEEF, 32'h0000_1000, 2'd2, 0, 1);
    // Store byte in kseg1.
    xact(4'b0100, 32'hA000_0022, 32'hABAB_ABAB, 32'h0, 32'h0000_0022, 2'd0, 0, 1);
    // Half store, kseg1 top; byte store low bits forced to enabled lane; unaligned load.
    xact(4'b1100, 32'hBFC0_0016, 32'h1234_1234, 32'h0, 32'h1FC0_0016, 2'd1, 1, 0);
    xact(4'b0010, 32'h0000_0043, 32'h7777_7777, 32'h0, 32'h0000_0041, 2'd0, 0, 2);
    xact(4'b0000, 32'h8000_1003, 32'h0, 32'h0102_0304, 32'h0000_1000, 2'd2, 2, 0);

    // Load completes while pipe stays frozen: DONE, no re-issue, buffered data.
    exp_req_q.push_back('{wr: 1'b0, size: 2'd2, addr: 32'h0000_0100, wdata: 32'h0});
    en = 1'b1; cwen = 4'b0; caddr = 32'h0000_0100; aok = 1'b1;
    @(negedge clk); chk("frz_stall0", {31'd0, d_stall}, 32'd1);
    nxt();
    aok = 1'b0; dok = 1'b1; rdat = 32'h1234_5678; ext = 1'b1;
    exp_rd_q.push_back(32'h1234_5678);
    @(negedge clk); chk("frz_stall1", {31'd0, d_stall}, 32'd0);
    nxt();
    dok = 1'b0; rdat = 32'hFFFF_FFFF; aok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ext = (i < 3);
      @(negedge clk);
      chk("done_req", {31'd0, bus.data_req}, 32'd0);
      chk("done_stall", {31'd0, d_stall}, 32'd0);
      chk("done_rdata", cpu_rdata, 32'h1234_5678);
      nxt();
    end
    ext = 1'b0; en = 1'b0; aok = 1'b0;
    @(negedge clk);
    chk("post_done_req", {31'd0, bus.data_req}, 32'd0);
    nxt();

    // addr_ok withheld 4 cycles while cpu_addr/cpu_wdata move.
    exp_req_q.push_back('{wr: 1'b1, size: 2'd2, addr: 32'h0000_2004, wdata: 32'hCAFE_F00D});
    en = 1'b1; cwen = 4'b1111; caddr = 32'h0000_2004; cwdata = 32'hCAFE_F00D;
    for (int i = 0; i <= 4; i++) begin
      aok = (i == 4);
      @(negedge clk);
      chk("hold_addr", bus.data_addr, 32'h0000_2004);
      chk("hold_wdata", bus.data_wdata, 32'hCAFE_F00D);
      chk("hold_stall", {31'd0, d_stall}, 32'd1);
      nxt();
      caddr = 32'h0000_3000 + 32'(i * 4);
      cwdata = $urandom;
    end
    aok = 1'b0;
    @(negedge clk); chk("hold_data_req", {31'd0, bus.data_req}, 32'd0);
    nxt();
    dok = 1'b1;
    @(negedge clk); chk("hold_done_stall", {31'd0, d_stall}, 32'd0);
    nxt();
    dok = 1'b0; en = 1'b0; cwen = 4'b0;

    // Flush in DATA: no stall, data_ok swallowed, then a fresh request.
    exp_req_q.push_back('{wr: 1'b0, size: 2'd2, addr: 32'h0000_0040, wdata: 32'h0});
    en = 1'b1; caddr = 32'h8000_0040; aok = 1'b1;
    @(negedge clk); chk("flush_issue", {31'd0, d_stall}, 32'd1);
    nxt();
    aok = 1'b0; en = 1'b0;
    @(negedge clk); chk("flush_stall", {31'd0, d_stall}, 32'd0);
    nxt();
    dok = 1'b1; rdat = 32'h5555_5555;
    @(negedge clk); chk("flush_dok_req", {31'd0, bus.data_req}, 32'd0);
    nxt();
    dok = 1'b0;
    xact(4'b0000, 32'h0000_0080, 32'h0, 32'h0BAD_F00D, 32'h0000_0080, 2'd2, 0, 0);

    // Reset while parked in ADDR.
    en = 1'b1; cwen = 4'b0; caddr = 32'h0000_0200; aok = 1'b0;
    @(negedge clk); chk("rstaddr_req0", {31'd0, bus.data_req}, 32'd1);
    nxt();
    en = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk("rstaddr_req1", {31'd0, bus.data_req}, 32'd1);
    chk("rstaddr_stall", {31'd0, d_stall}, 32'd0);
    nxt();
    rst = 1'b0;
    @(negedge clk);
    chk("rstaddr_req2", {31'd0, bus.data_req}, 32'd0);
    chk("rstaddr_stall2", {31'd0, d_stall}, 32'd0);
    chk("rstaddr_rdata", cpu_rdata, 32'd0);
    nxt();
    xact(4'b0000, 32'h0000_0300, 32'h0, 32'hA5A5_A5A5, 32'h0000_0300, 2'd2, 1, 0);

    repeat (2) nxt();
    chk("req_q_empty", 32'(exp_req_q.size()), 32'd0);
    chk("rd_q_empty", 32'(exp_rd_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
